// File: rtl/kernel_scan_ctrl.sv
// Raster-scan scheduler for the kernel filter stages: walks a KxK window over the image file
// band by band, issuing column read addresses, filter enables and delayed write-back addresses.
module kernel_scan_ctrl #(
    parameter int unsigned IMG_DIM = 20,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned LAT     = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_ksize,
    input  logic              i_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sub_clear,
    output logic              o_rd_valid,
    output logic [ADDR_W-1:0] o_rd_addr0,
    output logic [ADDR_W-1:0] o_rd_addr1,
    output logic [ADDR_W-1:0] o_rd_addr2,
    output logic [ADDR_W-1:0] o_rd_addr3,
    output logic [ADDR_W-1:0] o_rd_addr4,
    output logic              o_filt_en,
    output logic              o_wr_valid,
    output logic [ADDR_W-1:0] o_wr_addr
);

    localparam int unsigned CW = $clog2(IMG_DIM);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StScan,
        StGap,
        StDrain,
        StDone
    } state_e;

    state_e            r_state;
    logic              r_k5;
    logic [CW-1:0]     r_row;
    logic [CW-1:0]     r_col;
    logic [2:0]        r_drain;
    logic [LAT-1:0]    r_dl_vld;
    logic [ADDR_W-1:0] r_dl_addr [LAT];

    logic              w_scan;
    logic              w_adv;
    logic              w_filt;
    logic              w_col_last;
    logic              w_row_last;
    logic [CW-1:0]     w_kmin1;
    logic [CW-1:0]     w_last_row;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_rd_addr [5];

    assign w_kmin1    = r_k5 ? CW'(4) : CW'(2);
    assign w_last_row = r_k5 ? CW'(IMG_DIM - 5) : CW'(IMG_DIM - 3);
    assign w_col_last = (r_col == CW'(IMG_DIM - 1));
    assign w_row_last = (r_row == w_last_row);
    assign w_scan     = (r_state == StScan);
    assign w_adv      = w_scan && !i_hold;
    assign w_filt     = w_adv && (r_col >= w_kmin1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_k5    <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_drain <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_k5    <= i_ksize;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_state <= StClear;
                    end
                end
                StClear: begin
                    r_row   <= '0;
                    r_col   <= '0;
                    r_state <= StScan;
                end
                StScan: begin
                    if (!i_hold) begin
                        if (w_col_last) begin
                            r_drain <= '0;
                            r_state <= w_row_last ? StDrain : StGap;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                StGap: begin
                    r_row   <= r_row + 1'b1;
                    r_col   <= '0;
                    r_state <= StScan;
                end
                StDrain: begin
                    if (r_drain == 3'(LAT - 1)) begin
                        r_state <= StDone;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Rows beyond the active kernel height stay at zero.
    always_comb begin
        for (int n = 0; n < 5; n++) begin
            w_rd_addr[n] = '0;
            if (w_scan && (n < (r_k5 ? 5 : 3))) begin
                w_rd_addr[n] = ADDR_W'((int'(r_row) + n) * int'(IMG_DIM) + int'(r_col));
            end
        end
    end

    // Window centre: one half-kernel down from the band top, one half-kernel left of the column.
    always_comb begin
        w_wr_addr = '0;
        if (w_filt) begin
            w_wr_addr = ADDR_W'((int'(r_row) + (r_k5 ? 2 : 1)) * int'(IMG_DIM)
                                + int'(r_col) - (r_k5 ? 2 : 1));
        end
    end

    // Free-running delay line so in-flight results survive hold and the end of the scan.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dl_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_dl_addr[i] <= '0;
            end
        end else begin
            r_dl_vld[0]  <= w_filt;
            r_dl_addr[0] <= w_wr_addr;
            for (int i = 1; i < LAT; i++) begin
                r_dl_vld[i]  <= r_dl_vld[i-1];
                r_dl_addr[i] <= r_dl_addr[i-1];
            end
        end
    end

    always_comb begin
        o_busy      = (r_state == StClear) || (r_state == StScan) ||
                      (r_state == StGap)   || (r_state == StDrain);
        o_done      = (r_state == StDone);
        o_sub_clear = (r_state == StClear) || (r_state == StGap);
        o_rd_valid  = w_adv;
        o_filt_en   = w_filt;
        o_rd_addr0  = w_rd_addr[0];
        o_rd_addr1  = w_rd_addr[1];
        o_rd_addr2  = w_rd_addr[2];
        o_rd_addr3  = w_rd_addr[3];
        o_rd_addr4  = w_rd_addr[4];
        o_wr_valid  = r_dl_vld[LAT-1];
        o_wr_addr   = r_dl_addr[LAT-1];
    end

endmodule

// File: tb/tb_kernel_scan_ctrl.sv
// Bench for kernel_scan_ctrl: two instances (LAT=1 and LAT=3) share stimulus; table-driven frames
// plus a hand-written mid-scan reset sequence.
module tb_kernel_scan_ctrl;

    localparam int DIM = 20;
    localparam int AW  = 9;

    logic clk = 1'b0;
    logic rst, start, ksize, hold;

    logic a_busy, a_done, a_sclr, a_rdv, a_fe, a_wv;
    logic [AW-1:0] a_rd0, a_rd1, a_rd2, a_rd3, a_rd4, a_wa;
    logic b_busy, b_done, b_sclr, b_rdv, b_fe, b_wv;
    logic [AW-1:0] b_rd0, b_rd1, b_rd2, b_rd3, b_rd4, b_wa;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    kernel_scan_ctrl #(.IMG_DIM(DIM), .ADDR_W(AW), .LAT(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_ksize(ksize), .i_hold(hold),
        .o_busy(a_busy), .o_done(a_done), .o_sub_clear(a_sclr), .o_rd_valid(a_rdv),
        .o_rd_addr0(a_rd0), .o_rd_addr1(a_rd1), .o_rd_addr2(a_rd2), .o_rd_addr3(a_rd3),
        .o_rd_addr4(a_rd4), .o_filt_en(a_fe), .o_wr_valid(a_wv), .o_wr_addr(a_wa)
    );

    kernel_scan_ctrl #(.IMG_DIM(DIM), .ADDR_W(AW), .LAT(3)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_ksize(ksize), .i_hold(hold),
        .o_busy(b_busy), .o_done(b_done), .o_sub_clear(b_sclr), .o_rd_valid(b_rdv),
        .o_rd_addr0(b_rd0), .o_rd_addr1(b_rd1), .o_rd_addr2(b_rd2), .o_rd_addr3(b_rd3),
        .o_rd_addr4(b_rd4), .o_filt_en(b_fe), .o_wr_valid(b_wv), .o_wr_addr(b_wa)
    );

    typedef struct {
        bit              k5;
        bit              flip_ksize;
        int              hold_lo;
        int              hold_hi;
        int              spur_start;
        int              exp_hold_rd0;
        int              exp_done_a;
        int              exp_done_b;
        int              exp_writes;
        int              exp_first_wr;
        int              exp_last_wr;
        int              exp_last_wr_cyc_b;
        int              exp_first_filt;
        int              exp_subclr;
        logic [4:0][15:0] exp_rd2;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int nonzero_outputs();
        int n = 0;
        n += int'(a_busy) + int'(a_done) + int'(a_sclr) + int'(a_rdv) + int'(a_fe) + int'(a_wv);
        n += int'(b_busy) + int'(b_done) + int'(b_sclr) + int'(b_rdv) + int'(b_fe) + int'(b_wv);
        n += int'(|{a_rd0, a_rd1, a_rd2, a_rd3, a_rd4, a_wa});
        n += int'(|{b_rd0, b_rd1, b_rd2, b_rd3, b_rd4, b_wa});
        return n;
    endfunction

    // Entered #1 after a rising edge; that cycle is cycle 0 with start asserted.
    task automatic run_frame(input vec_t v, input int idx);
        int kk, hh, nb;
        int done_a, done_b, ndone_a, nwr, first_wr, last_wr, last_wr_b, first_filt, nsclr;
        int hold_bad, seq_bad, dl_bad, busy1, busy_at_done, rdv2;
        int exp_seq [$];
        bit hist_a [$];
        bit hist_b [$];
        logic [4:0][15:0] rd2;
        string p;
        p  = $sformatf("v%0d", idx);
        kk = v.k5 ? 5 : 3;
        hh = kk / 2;
        nb = DIM - kk + 1;
        for (int r = 0; r < nb; r++)
            for (int c = kk - 1; c < DIM; c++)
                exp_seq.push_back((r + hh) * DIM + c - hh);
        hist_a = '{0};
        hist_b = '{0, 0, 0};
        done_a = -1; done_b = -1; ndone_a = 0; nwr = 0; first_wr = -1; last_wr = -1;
        last_wr_b = -1; first_filt = -1; nsclr = 0; hold_bad = 0; seq_bad = 0; dl_bad = 0;
        busy1 = 0; busy_at_done = -1; rdv2 = 0; rd2 = '0;
        for (int t = 0; t < 700 && (done_a < 0 || done_b < 0); t++) begin
            start = (t == 0) || (t == v.spur_start);
            ksize = (t == 0 || !v.flip_ksize) ? v.k5 : ~v.k5;
            hold  = (t >= v.hold_lo) && (t <= v.hold_hi);
            @(negedge clk);
            if (a_fe && first_filt < 0) first_filt = t;
            if (a_wv) begin
                if (first_wr < 0) first_wr = int'(a_wa);
                last_wr = int'(a_wa);
                if (nwr >= exp_seq.size() || int'(a_wa) != exp_seq[nwr]) seq_bad++;
                nwr++;
            end
            if (b_wv) last_wr_b = t;
            if (a_wv !== hist_a[t]) dl_bad++;
            if (b_wv !== hist_b[t]) dl_bad++;
            if (b_wv && a_wv !== 1'b1 && t >= 2 && b_wa == 9'd0) dl_bad++;
            hist_a.push_back(a_fe);
            hist_b.push_back(b_fe);
            if (a_sclr) nsclr++;
            if (t == 1) busy1 = int'(a_busy && b_busy && a_sclr);
            if (t == 2) begin
                rdv2 = int'(a_rdv);
                rd2  = {16'(a_rd4), 16'(a_rd3), 16'(a_rd2), 16'(a_rd1), 16'(a_rd0)};
            end
            if (t >= v.hold_lo && t <= v.hold_hi) begin
                if (a_rdv || a_fe || int'(a_rd0) != v.exp_hold_rd0) hold_bad++;
            end
            if (t == v.hold_hi + 1) begin
                if (!a_rdv || int'(a_rd0) != v.exp_hold_rd0) hold_bad++;
            end
            if (a_done) begin
                ndone_a++;
                if (done_a < 0) begin
                    done_a = t;
                    busy_at_done = int'(a_busy);
                end
            end
            if (b_done && done_b < 0) done_b = t;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        hold  = 1'b0;
        chk({p, "_done_cycle_lat1"}, done_a, v.exp_done_a);
        chk({p, "_done_cycle_lat3"}, done_b, v.exp_done_b);
        chk({p, "_done_pulses"}, ndone_a, 1);
        chk({p, "_busy_at_done"}, busy_at_done, 0);
        chk({p, "_clear_cycle1"}, busy1, 1);
        chk({p, "_writes"}, nwr, v.exp_writes);
        chk({p, "_first_wr_addr"}, first_wr, v.exp_first_wr);
        chk({p, "_last_wr_addr"}, last_wr, v.exp_last_wr);
        chk({p, "_last_wr_cycle_lat3"}, last_wr_b, v.exp_last_wr_cyc_b);
        chk({p, "_wr_sequence_errs"}, seq_bad, 0);
        chk({p, "_delay_line_errs"}, dl_bad, 0);
        chk({p, "_first_filt_en"}, first_filt, v.exp_first_filt);
        chk({p, "_sub_clear_count"}, nsclr, v.exp_subclr);
        chk({p, "_hold_errs"}, hold_bad, 0);
        chk({p, "_rd_valid_c2"}, rdv2, 1);
        for (int n = 0; n < 5; n++)
            chk($sformatf("%s_rd_addr%0d_c2", p, n), int'(rd2[n]), int'(v.exp_rd2[n]));
    endtask

    initial begin
        vecs[0] = '{k5: 0, flip_ksize: 0, hold_lo: -1, hold_hi: -2, spur_start: -1,
                    exp_hold_rd0: 0, exp_done_a: 380, exp_done_b: 382, exp_writes: 324,
                    exp_first_wr: 21, exp_last_wr: 378, exp_last_wr_cyc_b: 381,
                    exp_first_filt: 4, exp_subclr: 18,
                    exp_rd2: {16'd0, 16'd0, 16'd40, 16'd20, 16'd0}};
        vecs[1] = '{k5: 1, flip_ksize: 0, hold_lo: -1, hold_hi: -2, spur_start: -1,
                    exp_hold_rd0: 0, exp_done_a: 338, exp_done_b: 340, exp_writes: 256,
                    exp_first_wr: 42, exp_last_wr: 357, exp_last_wr_cyc_b: 339,
                    exp_first_filt: 6, exp_subclr: 16,
                    exp_rd2: {16'd80, 16'd60, 16'd40, 16'd20, 16'd0}};
        vecs[2] = '{k5: 0, flip_ksize: 0, hold_lo: 3, hold_hi: 5, spur_start: -1,
                    exp_hold_rd0: 1, exp_done_a: 383, exp_done_b: 385, exp_writes: 324,
                    exp_first_wr: 21, exp_last_wr: 378, exp_last_wr_cyc_b: 384,
                    exp_first_filt: 7, exp_subclr: 18,
                    exp_rd2: {16'd0, 16'd0, 16'd40, 16'd20, 16'd0}};
        vecs[3] = '{k5: 0, flip_ksize: 1, hold_lo: -1, hold_hi: -2, spur_start: 100,
                    exp_hold_rd0: 0, exp_done_a: 380, exp_done_b: 382, exp_writes: 324,
                    exp_first_wr: 21, exp_last_wr: 378, exp_last_wr_cyc_b: 381,
                    exp_first_filt: 4, exp_subclr: 18,
                    exp_rd2: {16'd0, 16'd0, 16'd40, 16'd20, 16'd0}};

        rst   = 1'b1;
        start = 1'b0;
        ksize = 1'b0;
        hold  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", nonzero_outputs(), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_outputs_zero", nonzero_outputs(), 0);

        for (int i = 0; i < 4; i++) run_frame(vecs[i], i);

        // Mid-scan reset at cycle 150, then a clean frame.
        start = 1'b1;
        ksize = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (149) @(posedge clk);
        #1;
        chk("busy_before_reset", int'(a_busy && b_busy), 1);
        rst = 1'b1;
        #1;
        chk("midscan_reset_outputs_zero", nonzero_outputs(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post_reset_idle_%0d", i), nonzero_outputs(), 0);
            @(posedge clk);
            #1;
        end
        run_frame(vecs[0], 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kernel_scan_ctrl.md
# kernel_scan_ctrl

Raster-scan scheduler for the edge-detection pipeline's kernel stages. On `start` it walks a K×K window (K = 3 or 5) over the IMG_DIM×IMG_DIM image register file, band by band. Each cycle it issues one column of K row read addresses to the image file. It tells the active filter sub-module (median/Gaussian/Sobel/non-max/hysteresis) when a full window is present. It also produces the write-back address of each filter result in the temp file. The top-level stage FSM invokes it once per filter stage.

## Interface
- `IMG_DIM`, default 20: image width and height in pixels.
- `ADDR_W`, default 9: address width; must satisfy 2^ADDR_W ≥ IMG_DIM².
- `LAT`, default 1: filter pipeline latency from `filt_en` to valid result; legal range 1..7.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; all state and outputs are cleared immediately.
- `start` in 1: begin a frame scan; sampled only in IDLE.
- `ksize` in 1: 0 = 3×3, 1 = 5×5; latched when `start` is accepted.
- `hold` in 1: stall the column advance during SCAN.
- `busy` out 1: high from CLEAR through DRAIN.
- `done` out 1: one-cycle pulse in DONE.
- `sub_clear` out 1: synchronous clear to the filter sub-module.
- `rd_valid` out 1: the `rd_addr*` outputs carry a valid column this cycle.
- `rd_addr0`..`rd_addr4` out ADDR_W each: row addresses of the current window column. Rows at or above K output 0.
- `filt_en` out 1: the window is complete; the filter must produce a result.
- `wr_valid` out 1: the filter result is present; write it to `wr_addr`.
- `wr_addr` out ADDR_W: temp-file address of the window centre.

## Operation
- K = 3 or 5, H = K/2 (1 or 2). Band count NB = IMG_DIM−K+1. The band top row is r (0..NB−1) and the column counter is c (0..IMG_DIM−1).
- State IDLE: the block waits. `start`=1 latches K, then moves to CLEAR.
- State CLEAR: one cycle, with `sub_clear`=1 and r=0, c=0. Then moves to SCAN.
- State SCAN:
  - When `hold`=0: `rd_valid`=1 and `rd_addrN` = (r+N)·IMG_DIM + c for N<K.
  - `filt_en` = 1 when c ≥ K−1.
  - c then increments.
  - When c = IMG_DIM−1: if r < NB−1, go to GAP; otherwise go to DRAIN.
- SCAN with `hold`=1: `rd_valid`=0 and `filt_en`=0. c and r are frozen.
- State GAP: one cycle, with `sub_clear`=1, `rd_valid`=0, r increments and c resets to 0. Then returns to SCAN.
- State DRAIN: LAT cycles, with no reads. Then moves to DONE.
- State DONE: `done`=1 and `busy`=0 for one cycle. Then returns to IDLE.
- The address computed at each `filt_en` is (r+H)·IMG_DIM + (c−H). The row products use a constant multiply by IMG_DIM; no truncation occurs under the parameter constraint.
- That address and `filt_en` pass through a LAT-deep delay line, which emerges as `wr_addr`/`wr_valid`.
- The delay line advances every cycle regardless of state or `hold`, so results already in flight are never lost.
- Writes per frame: NB². That is 324 for K=3 (addresses 21..378) and 256 for K=5 (addresses 42..357).
- `start` outside IDLE is ignored. `ksize` changes after acceptance are ignored.

## Timing
- Reset values:
  - State = IDLE.
  - `busy`, `done`, `sub_clear`, `rd_valid`, `filt_en` and `wr_valid` = 0.
  - All addresses = 0.
  - The delay line is zeroed.
- Control outputs are Moore-decoded from registered state/counters; `rd_*` and `filt_en` are valid in the same cycle as the SCAN state.
- `wr_valid` at cycle t equals `filt_en` at cycle t−LAT, exactly.
- Cycle timeline, with `start` sampled at cycle 0:
  - CLEAR occurs at cycle 1.
  - The first SCAN is cycle 2.
  - With no hold, SCAN+GAP spans NB·IMG_DIM + NB−1 cycles. That is cycles 2..378 for K=3 and 2..336 for K=5.
  - DRAIN occupies the next LAT cycles, followed by DONE.
- Each `hold` cycle extends the timeline by one cycle.
- A reset mid-scan returns to IDLE with all outputs 0, including any in-flight `wr_valid`. No `done` is produced.

## Test plan
- K=3, LAT=1, no hold:
  - Cycle 2: `rd_addr0/1/2` = 0/20/40 with `rd_valid`=1.
  - First `filt_en` at cycle 4; first `wr_valid` at cycle 5 with `wr_addr`=21.
  - 324 writes in total; the last write has `wr_addr`=378 at cycle 379.
  - `done` at cycle 380.
- K=5, LAT=1:
  - Cycle 2: `rd_addr0..4` = 0/20/40/60/80.
  - First `wr_addr`=42 and last `wr_addr`=357; 256 writes.
  - `done` at cycle 338.
- K=3, `hold` high for cycles 3..5:
  - `rd_valid`=0 in those cycles and addresses are unchanged.
  - The first `filt_en` moves from cycle 4 to cycle 7.
  - `done` occurs 3 cycles later, at cycle 383.
- `start` pulsed at cycle 100 of a running scan: no effect. `sub_clear` is seen only at cycle 1 and at the 17 GAP cycles.
- K=3 with `reset` asserted at cycle 150:
  - All outputs are 0 immediately.
  - A following `start` produces a clean full frame identical to the first scenario.
- LAT=3, K=3: the last `wr_valid` is at cycle 381 with `wr_addr`=378; DRAIN lasts 3 cycles; `done` at cycle 382.
